// File: rtl/fnd_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller:
// register indices, control-bit layout, converter states and the glyph table.
package fnd_pkg;

  localparam logic [2:0] REG_FCR = 3'd0;
  localparam logic [2:0] REG_FDR = 3'd1;
  localparam logic [2:0] REG_FPR = 3'd2;
  localparam logic [2:0] REG_FBR = 3'd3;
  localparam logic [2:0] REG_FSR = 3'd4;

  localparam int FCR_EN    = 0;
  localparam int FCR_HEX   = 1;
  localparam int FCR_BLINK = 2;

  typedef struct packed {
    logic blink;
    logic hex;
    logic en;
  } fcr_t;

  typedef enum logic {
    CONV_IDLE = 1'b0,
    CONV_RUN  = 1'b1
  } conv_state_e;

  // Active-low segments {dp, g, f, e, d, c, b, a}; dp is left off here.
  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/fnd_bin2bcd_seq.sv
// Serial double-dabble converter: one input bit per cycle, DATA_W cycles per
// conversion, result truncated to NUM_DIGITS digits with a carry-out flag.
module fnd_bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    start,
  input  logic [DATA_W-1:0]       value,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  conv_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic [BCD_W-1:0]  acc_q;
  logic [BCD_W-1:0]  acc_adj;
  logic [BCD_W-1:0]  acc_next;
  logic              ovf_acc_q;
  logic              carry;
  logic              last;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    acc_adj = acc_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_next = {acc_adj[BCD_W-2:0], sh_q[DATA_W-1]};
    carry    = acc_adj[BCD_W-1];
    last     = (state_q == CONV_RUN) && (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
    if (PRESET) state_q <= CONV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)     state_d = CONV_RUN;
    else if (last) state_d = CONV_IDLE;
  end

  always_comb begin
    busy = (state_q == CONV_RUN);
  end

  // A start while running simply reloads, discarding the partial result.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q     <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh_q      <= value;
        acc_q     <= '0;
        ovf_acc_q <= 1'b0;
        cnt_q     <= CNT_W'(DATA_W);
      end else if (busy) begin
        sh_q      <= sh_q << 1;
        acc_q     <= acc_next;
        ovf_acc_q <= ovf_acc_q | carry;
        cnt_q     <= cnt_q - CNT_W'(1);
        if (last) begin
          done <= 1'b1;
          bcd  <= acc_next;
          ovf  <= ovf_acc_q | carry;
        end
      end
    end
  end

endmodule

// File: rtl/apb_fnd_scan_ctrl.sv
// APB slave scanning an N-digit multiplexed 7-segment display, with decimal
// (serial BCD) or hex display, per-digit decimal points and blinking.
module apb_fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [4:0]            PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic [NUM_DIGITS-1:0] FND_comm,
  output logic [7:0]            FND_font
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;

  fcr_t                  fcr_q;
  logic [31:0]           fdr_q;
  logic [NUM_DIGITS-1:0] fpr_q;
  logic [NUM_DIGITS-1:0] fbr_q;
  logic [BCD_W-1:0]      digit_q;
  logic                  ovf_q;

  logic [2:0]            reg_sel;
  logic                  access;
  logic                  wr_en;
  logic [31:0]           rd_mux;
  logic                  unused_addr;

  logic                  conv_start;
  logic [DATA_W-1:0]     conv_value;
  logic                  conv_busy;
  logic                  conv_done;
  logic [BCD_W-1:0]      conv_bcd;
  logic                  conv_ovf;
  logic                  hex_ovf;

  logic [PRE_W-1:0]      pre_q;
  logic [IDX_W-1:0]      idx_q;
  logic [BLK_W-1:0]      blk_q;
  logic                  phase_q;
  logic                  tick;

  logic [3:0]            cur_digit;
  logic [7:0]            glyph;
  logic                  blank;
  logic [7:0]            font_d;
  logic [NUM_DIGITS-1:0] comm_d;

  assign reg_sel     = PADDR[4:2];
  assign unused_addr = ^PADDR[1:0];
  assign access      = PSEL & PENABLE;
  assign wr_en       = PREADY & access & PWRITE;

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_FCR: rd_mux = 32'(fcr_q);
      REG_FDR: rd_mux = fdr_q;
      REG_FPR: rd_mux = 32'(fpr_q);
      REG_FBR: rd_mux = 32'(fbr_q);
      REG_FSR: rd_mux = {30'd0, ovf_q, conv_busy};
      default: rd_mux = '0;
    endcase
  end

  // One wait state: PREADY rises the cycle after the access phase starts and
  // drops on its own the cycle after that.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
    end else begin
      PREADY <= access & ~PREADY;
      PRDATA <= (access & ~PREADY & ~PWRITE) ? rd_mux : '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      fcr_q <= '0;
      fdr_q <= '0;
      fpr_q <= '0;
      fbr_q <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_FCR: fcr_q <= fcr_t'(PWDATA[2:0]);
        REG_FDR: fdr_q <= PWDATA;
        REG_FPR: fpr_q <= PWDATA[NUM_DIGITS-1:0];
        REG_FBR: fbr_q <= PWDATA[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  // The converter sees the value being written, not the stale register.
  always_comb begin
    conv_start = wr_en && (((reg_sel == REG_FDR) && !fcr_q.hex) ||
                           ((reg_sel == REG_FCR) && !PWDATA[FCR_HEX]));
    conv_value = (reg_sel == REG_FDR) ? PWDATA[DATA_W-1:0] : fdr_q[DATA_W-1:0];
    hex_ovf    = |(fdr_q >> BCD_W);
  end

  fnd_bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .start  (conv_start),
    .value  (conv_value),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd),
    .ovf    (conv_ovf)
  );

  // NOTE: the digit latch is a handful of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      digit_q <= '0;
      ovf_q   <= 1'b0;
    end else if (fcr_q.hex) begin
      digit_q <= fdr_q[BCD_W-1:0];
      ovf_q   <= hex_ovf;
    end else if (conv_done) begin
      digit_q <= conv_bcd;
      ovf_q   <= conv_ovf;
    end
  end

  assign tick = (pre_q == PRE_W'(SCAN_DIV - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pre_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
      if (tick) begin
        idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        if (blk_q == BLK_W'(BLINK_DIV - 1)) begin
          blk_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          blk_q <= blk_q + BLK_W'(1);
        end
      end
    end
  end

  always_comb begin
    cur_digit = digit_q[4*idx_q +: 4];
    glyph     = seg_glyph(cur_digit);
    if (fpr_q[idx_q]) glyph[7] = 1'b0;
    blank  = !fcr_q.en || (fcr_q.blink && phase_q && fbr_q[idx_q]);
    font_d = blank ? 8'hFF : glyph;
    comm_d = fcr_q.en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      FND_comm <= '1;
      FND_font <= 8'hFF;
    end else begin
      FND_comm <= comm_d;
      FND_font <= font_d;
    end
  end

endmodule

// File: tb/tb_apb_fnd_scan_ctrl.sv
// Directed-plus-random bench for apb_fnd_scan_ctrl against an arithmetic
// model of the register file, digit values, scan position and blink phase.
module tb_apb_fnd_scan_ctrl;

  localparam int N  = 4;
  localparam int DW = 14;
  localparam int SD = 4;
  localparam int BD = 2;

  localparam logic [4:0] A_FCR = 5'h00;
  localparam logic [4:0] A_FDR = 5'h04;
  localparam logic [4:0] A_FPR = 5'h08;
  localparam logic [4:0] A_FBR = 5'h0C;
  localparam logic [4:0] A_FSR = 5'h10;

  logic          PCLK    = 1'b0;
  logic          PRESET  = 1'b1;
  logic [4:0]    PADDR   = '0;
  logic          PSEL    = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE  = 1'b0;
  logic [31:0]   PWDATA  = '0;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic [N-1:0]  FND_comm;
  logic [7:0]    FND_font;

  int vectors     = 0;
  int miscompares = 0;
  int ecount      = 0;

  logic [7:0] glyph_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [2:0]   m_fcr;
  logic [31:0]  m_fdr;
  logic [N-1:0] m_fpr;
  logic [N-1:0] m_fbr;
  int           m_digit [N];
  logic         m_ovf;

  apb_fnd_scan_ctrl #(
    .NUM_DIGITS (N),
    .DATA_W     (DW),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .FND_comm (FND_comm),
    .FND_font (FND_font)
  );

  always #5 PCLK = ~PCLK;

  // Edges since reset release; the scan position is derived from this alone.
  always @(posedge PCLK) ecount <= PRESET ? 0 : ecount + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fcr = '0; m_fdr = '0; m_fpr = '0; m_fbr = '0; m_ovf = 1'b0;
    for (int i = 0; i < N; i++) m_digit[i] = 0;
  endtask

  // Digits as the display should eventually show them for the current FDR/FCR.
  task automatic model_refresh();
    longint v;
    longint p;
    if (m_fcr[1]) begin
      for (int i = 0; i < N; i++) m_digit[i] = int'((m_fdr >> (4 * i)) & 32'hF);
      m_ovf = (4 * N < 32) && ((m_fdr >> (4 * N)) != 0);
    end else begin
      v = longint'(m_fdr) % (longint'(1) << DW);
      p = 1;
      for (int i = 0; i < N; i++) begin
        m_digit[i] = int'((v / p) % 10);
        p = p * 10;
      end
      m_ovf = (v >= p);
    end
  endtask

  task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata);
    int n;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge PCLK);
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!PREADY && n < 8);
    rdata = PRDATA;
    check("pready_wait", 32'(n), 32'd1);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check("pready_single", 32'(PREADY), 32'd0);
    check("prdata_idle", PRDATA, 32'd0);
  endtask

  task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    apb(1'b1, addr, data, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    apb(1'b0, addr, 32'd0, rd);
    check(tag, rd, exp);
  endtask

  task automatic busy_length(input int exp_cycles);
    int n;
    n = 0;
    while (dut.conv_busy && n < 100) begin
      n++;
      @(negedge PCLK);
    end
    check("busy_cycles", 32'(n), 32'(exp_cycles));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dut.conv_busy && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    check("conv_done_in_time", 32'(n < 200), 32'd1);
    repeat (3) @(negedge PCLK);
  endtask

  task automatic check_display(input int cycles);
    int t, idx, ph;
    logic [N-1:0] ec;
    logic [7:0]   ef;
    repeat (2) @(negedge PCLK);
    for (int k = 0; k < cycles; k++) begin
      @(negedge PCLK);
      t   = (ecount - 1) / SD;
      idx = t % N;
      ph  = (t / BD) % 2;
      ec  = m_fcr[0] ? ~(N'(1) << idx) : '1;
      if (!m_fcr[0] || (m_fcr[2] && ph == 1 && m_fbr[idx])) begin
        ef = 8'hFF;
      end else begin
        ef = glyph_ref[m_digit[idx]];
        if (m_fpr[idx]) ef[7] = 1'b0;
      end
      check("fnd_comm", 32'(FND_comm), 32'(ec));
      check("fnd_font", 32'(FND_font), 32'(ef));
    end
  endtask

  task automatic fsr_check(input string tag);
    rd_check(tag, A_FSR, {30'd0, m_ovf, 1'b0});
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] dec_vals [6];

    model_reset();
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_comm", 32'(FND_comm), 32'hF);
    check("rst_font", 32'(FND_font), 32'hFF);
    check("rst_pready", 32'(PREADY), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    PRESET = 1'b0;

    for (int a = 0; a < 8; a++) rd_check("rst_reg", 5'(a * 4), 32'd0);
    check_display(8);

    // Decimal 1234: the FDR write restarts the conversion kicked off by FCR.
    wr_reg(A_FCR, 32'h1);
    m_fcr = 3'b001;
    wr_reg(A_FDR, 32'd1234);
    m_fdr = 32'd1234;
    model_refresh();
    busy_length(DW);
    wait_idle();
    fsr_check("fsr_1234");
    check_display(32);

    wr_reg(A_FDR, 32'd12345);
    m_fdr = 32'd12345;
    model_refresh();
    wait_idle();
    rd_check("fsr_12345", A_FSR, 32'h2);
    check_display(32);

    // Hex mode, including random values that may overflow 4 digits.
    wr_reg(A_FCR, 32'h3);
    m_fcr = 3'b011;
    wr_reg(A_FDR, 32'h0000BEEF);
    m_fdr = 32'h0000BEEF;
    model_refresh();
    check_display(32);
    fsr_check("fsr_beef");
    for (int r = 0; r < 3; r++) begin
      v = $urandom;
      if (r == 0) v = v & 32'h0000FFFF;
      wr_reg(A_FDR, v);
      m_fdr = v;
      model_refresh();
      check_display(16);
      fsr_check("fsr_hex_rand");
    end

    // Back to decimal: FCR write alone converts the current FDR.
    wr_reg(A_FCR, 32'h1);
    m_fcr = 3'b001;
    model_refresh();
    busy_length(DW);
    wait_idle();
    fsr_check("fsr_mode_switch");
    check_display(16);

    wr_reg(A_FPR, 32'hFFFF_FFF4);
    m_fpr = 4'b0100;
    rd_check("fpr_rb", A_FPR, 32'h4);

    // Restart mid-conversion: the old digits stay until 5678 completes.
    wr_reg(A_FDR, 32'd1234);
    check_display(4);
    wr_reg(A_FDR, 32'd5678);
    m_fdr = 32'd5678;
    model_refresh();
    busy_length(DW);
    wait_idle();
    fsr_check("fsr_5678");
    check_display(32);

    dec_vals[0] = 32'd9999;
    dec_vals[1] = 32'd10000;
    dec_vals[2] = 32'd16383;
    dec_vals[3] = 32'd0;
    dec_vals[4] = $urandom;
    dec_vals[5] = $urandom;
    for (int r = 0; r < 6; r++) begin
      wr_reg(A_FDR, dec_vals[r]);
      m_fdr = dec_vals[r];
      model_refresh();
      wait_idle();
      fsr_check("fsr_dec");
      check_display(16);
    end

    // Blink: digit 0 masked, then digits 0 and 2.
    wr_reg(A_FCR, 32'h5);
    m_fcr = 3'b101;
    model_refresh();
    wait_idle();
    wr_reg(A_FBR, 32'h1);
    m_fbr = 4'b0001;
    check_display(64);
    wr_reg(A_FBR, 32'h5);
    m_fbr = 4'b0101;
    check_display(64);
    rd_check("fbr_rb", A_FBR, 32'h5);
    rd_check("fcr_rb", A_FCR, 32'h5);

    // Writes to read-only or unmapped addresses change nothing.
    wr_reg(5'h1C, 32'hFFFF_FFFF);
    wr_reg(A_FSR, 32'hFFFF_FFFF);
    rd_check("fcr_after_unmapped", A_FCR, 32'h5);
    rd_check("unmapped_rd", 5'h14, 32'd0);
    fsr_check("fsr_after_ro_write");

    wr_reg(A_FCR, 32'h0);
    m_fcr = 3'b000;
    model_refresh();
    wait_idle();
    check_display(16);

    // Reset during a conversion aborts it and clears everything.
    wr_reg(A_FCR, 32'h1);
    wait_idle();
    wr_reg(A_FDR, 32'd4321);
    check("busy_before_reset", 32'(dut.conv_busy), 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    check("busy_after_reset", 32'(dut.conv_busy), 32'd0);
    check("comm_after_reset", 32'(FND_comm), 32'hF);
    model_reset();
    rd_check("fcr_after_reset", A_FCR, 32'd0);
    rd_check("fdr_after_reset", A_FDR, 32'd0);
    fsr_check("fsr_after_reset");
    check_display(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
